axis_out_pack: RTL and testbench
================================

AXIS_OUT_PACK -- requirements
Module: axis_out_pack

Interface
REQ-001: Parameter ROWS, default `ROWS, number of output rows per input word.
REQ-002: Parameter Y_BITS, default `Y_BITS, bits per row result.
REQ-003: Parameter IN_WIDTH, default ROWS*Y_BITS, input word width; SHALL be a multiple of 8.
REQ-004: Parameter OUT_WIDTH, default `M_OUTPUT_WIDTH_LF, output beat width; SHALL be an integer multiple RATIO = OUT_WIDTH/IN_WIDTH >= 1 of IN_WIDTH.
REQ-005: Parameter CNT_BITS, default 16, packet counter width.
REQ-006: aclk  input  1  single clock; all state updates on rising edge.
REQ-007: aresetn  input  1  reset, asynchronous and active-low.
REQ-008: s_valid  input  1  input word valid (from the output-shift stage).
REQ-009: s_ready  output  1  input word accepted when s_valid & s_ready.
REQ-010: s_data  input  IN_WIDTH  one word of ROWS results.
REQ-011: s_last  input  1  final word of packet.
REQ-012: m_axis_tvalid  output  1  output beat valid.
REQ-013: m_axis_tready  input  1  downstream ready.
REQ-014: m_axis_tdata  output  OUT_WIDTH  packed beat.
REQ-015: m_axis_tkeep  output  OUT_WIDTH/8  byte enables.
REQ-016: m_axis_tlast  output  1  final beat of packet.
REQ-017: pkt_count  output  CNT_BITS  packets fully emitted.

Function
REQ-018: Block SHALL pack consecutive accepted input words into lanes of an accumulator; first word of a beat in lane 0 (bits IN_WIDTH-1:0), word k in lane k.
REQ-019: Lane counter SHALL range 0..RATIO-1; increments per accepted non-completing word.
REQ-020: A word SHALL complete a beat when lane == RATIO-1 or s_last == 1.
REQ-021: On completing accept, accumulator plus current word SHALL load the output register next edge: m_axis_tvalid=1, tlast=s_last, lane counter and accumulator cleared to 0.
REQ-022: Latency: completing word accepted at edge N -> beat visible on m_axis from edge N (registered, one cycle after s_data presented).
REQ-023: m_axis_tkeep SHALL be all-ones for lanes 0..lane of completed beat, zero above; unfilled lanes of tdata SHALL be 0.
REQ-024: s_ready SHALL equal ~m_axis_tvalid | m_axis_tready (combinational); full throughput of one word per cycle when downstream ready.
REQ-025: m_axis_tvalid SHALL clear on m_axis_tvalid & m_axis_tready unless a new beat loads the same edge, in which case it stays 1 with new contents.
REQ-026: Output register contents SHALL be stable while m_axis_tvalid & ~m_axis_tready (AXI-Stream rule).
REQ-027: Non-completing accepts SHALL be blocked while output stalled (s_ready=0), preserving word order.
REQ-028: RATIO == 1 SHALL degenerate to a one-deep register slice with tkeep all-ones.
REQ-029: pkt_count SHALL increment by 1 on each handshake of a beat with tlast=1, wrapping modulo 2^CNT_BITS.
REQ-030: Simulation SHALL report an error at elaboration if OUT_WIDTH % IN_WIDTH != 0 or IN_WIDTH % 8 != 0.

Reset
REQ-031: aresetn low SHALL immediately clear m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, accumulator, lane counter, pkt_count to 0.
REQ-032: Reset asserted mid-packet SHALL discard partial accumulator and any pending beat; first word after release goes to lane 0.
REQ-033: After release, s_ready SHALL be 1 (output empty).

Verification (IN_WIDTH=32, OUT_WIDTH=128, RATIO=4)
REQ-034: Words 0x11111111..0x44444444, s_last on 4th, tready=1 -> one beat tdata=0x44444444_33333333_22222222_11111111, tkeep=0xFFFF, tlast=1, pkt_count=1.
REQ-035: Two words 0xAAAAAAAA,0xBBBBBBBB with s_last on 2nd -> tdata=0x0..0_BBBBBBBB_AAAAAAAA, tkeep=0x00FF, tlast=1.
REQ-036: 8 words no last, tready held 0 after first beat -> s_ready=0 once beat 1 pending; beat 1 stable; release tready -> beat 2 follows, no word lost or reordered.
REQ-037: Continuous 400 words, random s_last, tready=1 -> s_ready never 0, output words equal reference queue, pkt_count equals number of s_last.
REQ-038: aresetn pulsed low after 2 words of a packet -> all outputs 0 asynchronously; next 4 words form a fresh beat from lane 0.
REQ-039: 2^CNT_BITS+1 single-word packets -> pkt_count wraps to 1.

Source files
------------

// File: rtl/axis_out_pack.sv
// -----------------------------------------------------------------------------
// axis_out_pack
//
// Packs consecutive result words (ROWS results of Y_BITS each) into wider
// AXI-Stream beats. Word k of a beat lands in lane k (lane 0 = LSBs). A beat
// is emitted when the last lane is filled or when the word carries s_last;
// unfilled lanes are zero and have tkeep cleared. The output stage is a
// single registered slot, so a new beat can load on the same edge the
// previous one is taken.
//
// Ports
//   aclk, aresetn   : clock, asynchronous active-low reset
//   s_valid/s_ready : input word handshake (s_ready = ~m_axis_tvalid | m_axis_tready)
//   s_data, s_last  : input word and end-of-packet flag
//   m_axis_*        : packed output stream (tdata/tkeep/tlast/tvalid/tready)
//   pkt_count       : number of tlast beats handed downstream (wraps)
// -----------------------------------------------------------------------------
`ifndef ROWS
`define ROWS 4
`endif
`ifndef Y_BITS
`define Y_BITS 8
`endif
`ifndef M_OUTPUT_WIDTH_LF
`define M_OUTPUT_WIDTH_LF 128
`endif

module axis_out_pack #(
   parameter int ROWS      = `ROWS,
   parameter int Y_BITS    = `Y_BITS,
   parameter int IN_WIDTH  = ROWS * Y_BITS,
   parameter int OUT_WIDTH = `M_OUTPUT_WIDTH_LF,
   parameter int CNT_BITS  = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [IN_WIDTH-1:0]    s_data,
   input  logic                   s_last,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [OUT_WIDTH-1:0]   m_axis_tdata,
   output logic [OUT_WIDTH/8-1:0] m_axis_tkeep,
   output logic                   m_axis_tlast,
   output logic [CNT_BITS-1:0]    pkt_count
);

   localparam int RATIO     = OUT_WIDTH / IN_WIDTH;
   localparam int LANE_BITS = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int KEEP_W    = OUT_WIDTH / 8;
   localparam int LANE_KEEP = IN_WIDTH / 8;
   localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(RATIO - 1);

   generate
      if (((OUT_WIDTH % IN_WIDTH) != 0) || ((IN_WIDTH % 8) != 0) || (OUT_WIDTH < IN_WIDTH)) begin : g_bad_params
         $error("axis_out_pack: OUT_WIDTH must be a multiple of IN_WIDTH and IN_WIDTH a multiple of 8");
      end
   endgenerate

   logic [LANE_BITS-1:0] lane_r;
   logic [OUT_WIDTH-1:0] acc_r;
   logic                 tvalid_r;
   logic                 tlast_r;
   logic [OUT_WIDTH-1:0] tdata_r;
   logic [KEEP_W-1:0]    tkeep_r;
   logic [CNT_BITS-1:0]  pkt_cnt_r;

   logic                 ready_s;
   logic                 accept_s;
   logic                 complete_s;
   logic                 load_s;
   logic [OUT_WIDTH-1:0] beat_data_s;
   logic [KEEP_W-1:0]    beat_keep_s;

   // Handshake decode: any accept while the output slot is free or draining.
   assign ready_s    = ~tvalid_r | m_axis_tready;
   assign accept_s   = s_valid & ready_s;
   assign complete_s = (lane_r == LAST_LANE) | s_last;
   assign load_s     = accept_s & complete_s;

   // Merge the incoming word into its lane; keep covers lanes 0..lane_r.
   always_comb begin
      beat_data_s = {OUT_WIDTH{1'b0}};
      beat_keep_s = {KEEP_W{1'b0}};
      for (int k = 0; k < RATIO; k++) begin
         beat_data_s[k*IN_WIDTH +: IN_WIDTH] = (lane_r == LANE_BITS'(k)) ?
                                               s_data : acc_r[k*IN_WIDTH +: IN_WIDTH];
         beat_keep_s[k*LANE_KEEP +: LANE_KEEP] = (LANE_BITS'(k) <= lane_r) ?
                                                 {LANE_KEEP{1'b1}} : {LANE_KEEP{1'b0}};
      end
   end

   // Accumulator and lane counter; cleared whenever a beat is handed to the output slot.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lane_r <= {LANE_BITS{1'b0}};
         acc_r  <= {OUT_WIDTH{1'b0}};
      end else if (accept_s) begin
         if (complete_s) begin
            lane_r <= {LANE_BITS{1'b0}};
            acc_r  <= {OUT_WIDTH{1'b0}};
         end else begin
            lane_r <= lane_r + LANE_BITS'(1);
            acc_r  <= beat_data_s;
         end
      end
   end

   // Output slot: load a completed beat, otherwise drop valid once taken; contents hold while stalled.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tvalid_r <= 1'b0;
         tlast_r  <= 1'b0;
         tdata_r  <= {OUT_WIDTH{1'b0}};
         tkeep_r  <= {KEEP_W{1'b0}};
      end else if (load_s) begin
         tvalid_r <= 1'b1;
         tlast_r  <= s_last;
         tdata_r  <= beat_data_s;
         tkeep_r  <= beat_keep_s;
      end else if (tvalid_r & m_axis_tready) begin
         tvalid_r <= 1'b0;
      end
   end

   // Packet counter: one tick per tlast beat accepted downstream.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         pkt_cnt_r <= {CNT_BITS{1'b0}};
      end else if (tvalid_r & m_axis_tready & tlast_r) begin
         pkt_cnt_r <= pkt_cnt_r + CNT_BITS'(1);
      end
   end

   assign s_ready       = ready_s;
   assign m_axis_tvalid = tvalid_r;
   assign m_axis_tlast  = tlast_r;
   assign m_axis_tdata  = tdata_r;
   assign m_axis_tkeep  = tkeep_r;
   assign pkt_count     = pkt_cnt_r;

endmodule

// File: tb/tb_axis_out_pack.sv
// -----------------------------------------------------------------------------
// tb_axis_out_pack: table-driven packets, hand-written stall/reset/wrap
// sequences and randomized streams checked against a queue-based packing model.
// -----------------------------------------------------------------------------
module tb_axis_out_pack;

   localparam int IW = 32;
   localparam int OW = 128;
   localparam int KW = OW / 8;
   localparam int CW = 8;

   logic          aclk = 1'b0;
   logic          aresetn = 1'b0;
   logic          s_valid = 1'b0;
   logic          s_ready;
   logic [IW-1:0] s_data = '0;
   logic          s_last = 1'b0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic [OW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic          m_axis_tlast;
   logic [CW-1:0] pkt_count;

   always #5 aclk = ~aclk;

   axis_out_pack #(
      .ROWS(4), .Y_BITS(8), .IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_BITS(CW)
   ) dut (
      .aclk(aclk), .aresetn(aresetn),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .pkt_count(pkt_count)
   );

   typedef struct packed {
      logic [OW-1:0] d;
      logic [KW-1:0] k;
      logic          l;
   } beat_t;

   typedef struct {
      int            n;
      logic          last;
      logic [OW-1:0] words;
      logic [OW-1:0] exp_d;
      logic [KW-1:0] exp_k;
      logic          exp_l;
   } vec_t;

   beat_t got_q[$];
   beat_t exp_q[$];
   int    checks = 0;
   int    failures = 0;
   bit    ready_chk = 1'b0;
   bit    rnd_ready = 1'b0;
   beat_t prev_beat;
   bit    prev_stall = 1'b0;

   // reference model state: words of the beat being gathered
   logic [OW-1:0] m_acc;
   int            m_cnt;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s: bound expired", name);
   endtask

   // packing rule: words fill 32-bit slots from the bottom, a beat closes at 4 words or on last
   task automatic model_push(input logic [IW-1:0] w, input logic l);
      beat_t b;
      m_acc = m_acc | ({{(OW-IW){1'b0}}, w} << (m_cnt * IW));
      m_cnt++;
      if (m_cnt == OW / IW || l) begin
         b.d = m_acc;
         b.k = KW'((33'd1 << (m_cnt * (IW / 8))) - 33'd1);
         b.l = l;
         exp_q.push_back(b);
         m_acc = '0;
         m_cnt = 0;
      end
   endtask

   // monitor: record handshaken beats, check AXI stability and optional s_ready
   always @(negedge aclk) begin
      if (aresetn) begin
         if (prev_stall) begin
            chk("stall_valid", {159'd0, m_axis_tvalid}, 160'd1);
            chk("stall_stable", {15'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {15'd0, prev_beat});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            got_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
         end
         if (ready_chk) begin
            chk("s_ready_full_rate", {159'd0, s_ready}, 160'd1);
         end
         prev_stall <= m_axis_tvalid && !m_axis_tready;
         prev_beat  <= {m_axis_tdata, m_axis_tkeep, m_axis_tlast};
      end else begin
         prev_stall <= 1'b0;
      end
   end

   task automatic step_ready();
      if (rnd_ready) begin
         m_axis_tready = ($urandom_range(0, 3) != 0);
      end
   endtask

   // present one word and hold it until the cycle it is accepted
   task automatic send_word(input logic [IW-1:0] d, input logic l);
      bit ok;
      ok = 1'b0;
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      for (int t = 0; t < 200; t++) begin
         @(negedge aclk);
         if (s_ready) begin
            ok = 1'b1;
            break;
         end
         @(posedge aclk);
         #1;
         step_ready();
      end
      if (!ok) fail_now("send_word_timeout");
      @(posedge aclk);
      #1;
      step_ready();
   endtask

   task automatic idle(input int n);
      s_valid = 1'b0;
      s_last  = 1'b0;
      repeat (n) begin
         @(posedge aclk);
         #1;
         step_ready();
      end
   endtask

   task automatic expect_beat(input string name, input beat_t e);
      beat_t g;
      for (int t = 0; t < 50 && got_q.size() == 0; t++) begin
         @(negedge aclk);
         #1;
      end
      if (got_q.size() == 0) begin
         fail_now(name);
      end else begin
         g = got_q.pop_front();
         chk(name, {15'd0, g}, {15'd0, e});
      end
   endtask

   task automatic do_reset();
      s_valid = 1'b0;
      s_last  = 1'b0;
      aresetn = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      aresetn = 1'b1;
      got_q.delete();
      exp_q.delete();
      m_acc = '0;
      m_cnt = 0;
   endtask

   task automatic drain_and_compare(input string name);
      beat_t g;
      beat_t e;
      for (int t = 0; t < 300 && got_q.size() < exp_q.size(); t++) begin
         @(negedge aclk);
         #1;
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (got_q.size() == 0) begin
            fail_now({name, "_missing_beat"});
         end else begin
            g = got_q.pop_front();
            chk(name, {15'd0, g}, {15'd0, e});
         end
      end
      chk({name, "_extra_beats"}, 160'(got_q.size()), 160'd0);
      got_q.delete();
   endtask

   initial begin
      vec_t        vecs[5];
      logic [IW-1:0] w;
      logic          l;
      int            lasts;
      beat_t         b1;
      beat_t         b2;

      vecs[0] = '{4, 1'b1, 128'h44444444_33333333_22222222_11111111,
                  128'h44444444_33333333_22222222_11111111, 16'hFFFF, 1'b1};
      vecs[1] = '{2, 1'b1, 128'h00000000_00000000_BBBBBBBB_AAAAAAAA,
                  128'h00000000_00000000_BBBBBBBB_AAAAAAAA, 16'h00FF, 1'b1};
      vecs[2] = '{1, 1'b1, 128'h00000000_00000000_00000000_DEADBEEF,
                  128'h00000000_00000000_00000000_DEADBEEF, 16'h000F, 1'b1};
      vecs[3] = '{3, 1'b1, 128'h00000000_0F0F0F0F_89ABCDEF_01234567,
                  128'h00000000_0F0F0F0F_89ABCDEF_01234567, 16'h0FFF, 1'b1};
      vecs[4] = '{4, 1'b0, 128'h5A5A5A5A_A5A5A5A5_00000000_FFFFFFFF,
                  128'h5A5A5A5A_A5A5A5A5_00000000_FFFFFFFF, 16'hFFFF, 1'b0};

      // reset state
      repeat (2) @(posedge aclk);
      #1;
      chk("rst_tvalid", {159'd0, m_axis_tvalid}, 160'd0);
      chk("rst_tdata", {32'd0, m_axis_tdata}, 160'd0);
      chk("rst_tkeep", {144'd0, m_axis_tkeep}, 160'd0);
      chk("rst_pkt_count", {152'd0, pkt_count}, 160'd0);
      aresetn = 1'b1;
      #1;
      chk("rst_s_ready", {159'd0, s_ready}, 160'd1);
      m_axis_tready = 1'b1;
      m_acc = '0;
      m_cnt = 0;

      // table of single packets
      for (int v = 0; v < 5; v++) begin
         for (int k = 0; k < vecs[v].n; k++) begin
            send_word(vecs[v].words[k*IW +: IW], vecs[v].last && (k == vecs[v].n - 1));
         end
         idle(1);
         expect_beat($sformatf("table_beat%0d", v), {vecs[v].exp_d, vecs[v].exp_k, vecs[v].exp_l});
         if (v == 0) begin
            idle(2);
            chk("table_pkt_count_first", {152'd0, pkt_count}, 160'd1);
         end
      end
      idle(2);
      chk("table_pkt_count", {152'd0, pkt_count}, 160'd4);

      // stall: beat 1 held, word 5 must wait, beat 2 follows in order
      m_axis_tready = 1'b0;
      for (int k = 1; k <= 4; k++) send_word(32'hC0DE0000 | 32'(k), 1'b0);
      b1 = {128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001, 16'hFFFF, 1'b0};
      b2 = {128'hC0DE0008_C0DE0007_C0DE0006_C0DE0005, 16'hFFFF, 1'b0};
      s_valid = 1'b1;
      s_data  = 32'hC0DE0005;
      s_last  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge aclk);
         chk("stall_s_ready", {159'd0, s_ready}, 160'd0);
         chk("stall_beat1", {15'd0, m_axis_tdata, m_axis_tkeep, m_axis_tlast}, {15'd0, b1});
      end
      @(posedge aclk);
      #1;
      m_axis_tready = 1'b1;
      for (int k = 5; k <= 8; k++) send_word(32'hC0DE0000 | 32'(k), 1'b0);
      idle(1);
      expect_beat("stall_out_beat1", b1);
      expect_beat("stall_out_beat2", b2);
      idle(2);

      // asynchronous reset mid-packet
      send_word(32'hBAD00001, 1'b0);
      send_word(32'hBAD00002, 1'b0);
      idle(1);
      #2;
      aresetn = 1'b0;
      #1;
      chk("async_rst_tvalid", {159'd0, m_axis_tvalid}, 160'd0);
      chk("async_rst_tlast", {159'd0, m_axis_tlast}, 160'd0);
      chk("async_rst_tdata", {32'd0, m_axis_tdata}, 160'd0);
      chk("async_rst_tkeep", {144'd0, m_axis_tkeep}, 160'd0);
      chk("async_rst_pkt_count", {152'd0, pkt_count}, 160'd0);
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      got_q.delete();
      #1;
      chk("post_rst_s_ready", {159'd0, s_ready}, 160'd1);
      send_word(32'h0000000A, 1'b0);
      send_word(32'h0000000B, 1'b0);
      send_word(32'h0000000C, 1'b0);
      send_word(32'h0000000D, 1'b1);
      idle(1);
      expect_beat("post_rst_beat", {128'h0000000D_0000000C_0000000B_0000000A, 16'hFFFF, 1'b1});
      idle(2);
      chk("post_rst_pkt_count", {152'd0, pkt_count}, 160'd1);

      // random stream at full rate
      do_reset();
      m_axis_tready = 1'b1;
      ready_chk = 1'b1;
      lasts = 0;
      for (int i = 0; i < 400; i++) begin
         w = $urandom;
         l = ($urandom_range(0, 4) == 0) || (i == 399);
         if (l) lasts++;
         model_push(w, l);
         send_word(w, l);
      end
      idle(1);
      ready_chk = 1'b0;
      drain_and_compare("rand_full");
      idle(2);
      chk("rand_full_pkt_count", {152'd0, pkt_count}, {152'd0, CW'(lasts)});

      // random stream with gaps and downstream back-pressure
      do_reset();
      rnd_ready = 1'b1;
      lasts = 0;
      for (int i = 0; i < 300; i++) begin
         w = $urandom;
         l = ($urandom_range(0, 5) == 0) || (i == 299);
         if (l) lasts++;
         model_push(w, l);
         send_word(w, l);
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(1);
      rnd_ready = 1'b0;
      m_axis_tready = 1'b1;
      drain_and_compare("rand_bp");
      idle(2);
      chk("rand_bp_pkt_count", {152'd0, pkt_count}, {152'd0, CW'(lasts)});

      // counter wrap: 2^CW + 1 single-word packets
      do_reset();
      m_axis_tready = 1'b1;
      for (int i = 0; i < (1 << CW) + 1; i++) send_word(32'(i), 1'b1);
      idle(3);
      chk("pkt_count_wrap", {152'd0, pkt_count}, 160'd1);
      got_q.delete();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
